iob_ram_sp_arb: RTL and testbench

//  Two-requester round-robin arbiter and initialiser for one iob_ram_sp instance.
//  - Shares the single-port RAM's en/we/addr/d/q lines between requesters 0 and 1.
//  - Each requester uses a valid/ready request channel and gets a 1-cycle-latency read return.
//  - After reset it can sweep the whole RAM writing zeros before serving requests.

---
 rtl/iob_ram_sp_arb.sv | 105 ++++++++++
 tb/tb_iob_ram_sp_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ram_sp_arb.sv
// Two-requester round-robin front end for a single-port RAM. After reset it can
// zero-fill the whole RAM before accepting requests.
module iob_ram_sp_arb #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic [1:0]          req_valid_i,
  input  logic [1:0]          req_we_i,
  input  logic [2*ADDR_W-1:0] req_addr_i,
  input  logic [2*DATA_W-1:0] req_d_i,
  output logic [1:0]          req_ready_o,
  output logic [1:0]          rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                init_done_o,
  output logic                ram_en_o,
  output logic                ram_we_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_d_o,
  input  logic [DATA_W-1:0]   ram_d_i
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic              r_prio, w_prio_nxt;
  logic [1:0]        r_rvalid, w_rvalid_nxt;
  logic              w_grant;
  logic              w_g;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state  <= ST_RESET;
      r_cnt    <= '0;
      r_prio   <= 1'b0;
      r_rvalid <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_prio   <= w_prio_nxt;
      r_rvalid <= w_rvalid_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_prio_nxt   = r_prio;
    w_rvalid_nxt = 2'b00;
    w_grant      = 1'b0;
    w_g          = 1'b0;
    req_ready_o  = 2'b00;
    ram_en_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_addr_o   = '0;
    ram_d_o      = '0;

    unique case (r_state)
      ST_CLEAR: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = r_cnt;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == {ADDR_W{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        // Contention goes to prio; a lone requester wins regardless of prio.
        w_grant = |req_valid_i;
        w_g     = (&req_valid_i) ? r_prio : req_valid_i[1];
        if (w_grant) begin
          req_ready_o[w_g]  = 1'b1;
          ram_en_o          = 1'b1;
          ram_we_o          = req_we_i[w_g];
          ram_addr_o        = w_g ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
          ram_d_o           = w_g ? req_d_i[2*DATA_W-1:DATA_W]    : req_d_i[DATA_W-1:0];
          w_prio_nxt        = ~w_g;
          w_rvalid_nxt[w_g] = ~req_we_i[w_g];
        end
      end

      default: w_state_nxt = ST_RESET;
    endcase
  end

  // The RAM registers its output, so read data lines up with the delayed valid.
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = ram_d_i;
  assign init_done_o = (r_state == ST_RUN);

endmodule

// File: tb/tb_iob_ram_sp_arb.sv
// Bench for iob_ram_sp_arb: behavioural RAMs behind two instances (clear-on-reset
// and immediate-run), vector table for the arbitration sequence, read scoreboard.
module tb_iob_ram_sp_arb;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = '0, req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_d = '0;
  logic [1:0]    req_ready, rvalid;
  logic [DW-1:0] rdata;
  logic          init_done, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d, ram_q;

  logic          rst_b_n = 1'b0;
  logic [1:0]    b_valid = '0, b_we = '0;
  logic [2*AW-1:0] b_addr = '0;
  logic [2*DW-1:0] b_d = '0;
  logic [1:0]    b_ready, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          b_init_done, b_ram_en, b_ram_we;
  logic [AW-1:0] b_ram_addr;
  logic [DW-1:0] b_ram_d, b_ram_q;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] shadow [DEPTH];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic        k;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    we;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    exp_ready;
  } vec_t;
  vec_t tbl [16];

  always #5 clk = ~clk;

  iob_ram_sp_arb #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) u_dut (
    .clk_i(clk), .arst_n_i(rst_n),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr), .req_d_i(req_d),
    .req_ready_o(req_ready), .rvalid_o(rvalid), .rdata_o(rdata), .init_done_o(init_done),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_d_o(ram_d),
    .ram_d_i(ram_q)
  );

  iob_ram_sp_arb #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) u_dut_b (
    .clk_i(clk), .arst_n_i(rst_b_n),
    .req_valid_i(b_valid), .req_we_i(b_we), .req_addr_i(b_addr), .req_d_i(b_d),
    .req_ready_o(b_ready), .rvalid_o(b_rvalid), .rdata_o(b_rdata), .init_done_o(b_init_done),
    .ram_en_o(b_ram_en), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr), .ram_d_o(b_ram_d),
    .ram_d_i(b_ram_q)
  );

  // Read-first single-port RAM models with registered output.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem_a[ram_addr] <= ram_d;
      ram_q <= mem_a[ram_addr];
    end
    if (b_ram_en) begin
      if (b_ram_we) mem_b[b_ram_addr] <= b_ram_d;
      b_ram_q <= mem_b[b_ram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each accepted read must return on exactly the following cycle.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rvalid", 64'(rvalid), 64'(2'b01 << e.k));
        check("rdata", 64'(rdata), 64'(e.data));
      end else begin
        check("rvalid idle", 64'(rvalid), 64'd0);
      end
    end
  end

  // Drives one request cycle, checks the combinational grant and RAM drive,
  // and records the expected effect of the accepted access.
  task automatic apply(input int idx, input vec_t v);
    logic          g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    req_valid = v.valid;
    req_we    = v.we;
    req_addr  = {v.a1, v.a0};
    req_d     = {v.d1, v.d0};
    #1;
    check($sformatf("v%0d ready", idx), 64'(req_ready), 64'(v.exp_ready));
    g = v.exp_ready[1];
    a = g ? v.a1 : v.a0;
    d = g ? v.d1 : v.d0;
    if (v.exp_ready != 2'b00) begin
      check($sformatf("v%0d ram_en", idx), 64'(ram_en), 64'd1);
      check($sformatf("v%0d ram_we", idx), 64'(ram_we), 64'(v.we[g]));
      check($sformatf("v%0d ram_addr", idx), 64'(ram_addr), 64'(a));
      if (v.we[g]) begin
        check($sformatf("v%0d ram_d", idx), 64'(ram_d), 64'(d));
        shadow[a] = d;
      end else begin
        sb.push_back('{due: cyc + 1, k: g, data: shadow[a]});
      end
    end else begin
      check($sformatf("v%0d idle bus", idx), 64'({ram_en, ram_we, ram_addr, ram_d}), 64'd0);
    end
    @(posedge clk);
  endtask

  // Called on a negedge with the DUT in CLEAR; ends on the negedge n cycles later.
  task automatic sweep(input int n);
    req_valid = 2'b11;
    for (int i = 0; i < n; i++) begin
      #1;
      check($sformatf("clr%0d ready", i), 64'(req_ready), 64'd0);
      check($sformatf("clr%0d bus", i), 64'({ram_en, ram_we, ram_addr, ram_d}),
            64'({1'b1, 1'b1, 4'(i), {DW{1'b0}}}));
      check($sformatf("clr%0d init_done", i), 64'(init_done), 64'd0);
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i]  = 16'hF000 | 16'(i);
      mem_b[i]  = 16'h0100 + 16'(i);
      shadow[i] = '0;
    end

    //       valid  we     a0    a1    d0        d1        exp_ready
    tbl[0]  = '{2'b01, 2'b01, 4'd3, 4'd0, 16'hA5A5, 16'h0000, 2'b01};
    tbl[1]  = '{2'b01, 2'b00, 4'd3, 4'd0, 16'h0000, 16'h0000, 2'b01};
    tbl[2]  = '{2'b00, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00};
    tbl[3]  = '{2'b10, 2'b10, 4'd0, 4'd1, 16'h0000, 16'h1111, 2'b10};
    tbl[4]  = '{2'b10, 2'b10, 4'd0, 4'd2, 16'h0000, 16'h2222, 2'b10};
    tbl[5]  = '{2'b11, 2'b00, 4'd1, 4'd2, 16'h0000, 16'h0000, 2'b01};
    tbl[6]  = '{2'b11, 2'b00, 4'd1, 4'd2, 16'h0000, 16'h0000, 2'b10};
    tbl[7]  = '{2'b11, 2'b00, 4'd1, 4'd2, 16'h0000, 16'h0000, 2'b01};
    tbl[8]  = '{2'b11, 2'b00, 4'd1, 4'd2, 16'h0000, 16'h0000, 2'b10};
    tbl[9]  = '{2'b11, 2'b01, 4'd5, 4'd5, 16'hBEEF, 16'h0000, 2'b01};
    tbl[10] = '{2'b11, 2'b00, 4'd5, 4'd5, 16'h0000, 16'h0000, 2'b10};
    tbl[11] = '{2'b00, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00};
    tbl[12] = '{2'b11, 2'b11, 4'd6, 4'd7, 16'h6666, 16'h7777, 2'b01};
    tbl[13] = '{2'b11, 2'b11, 4'd6, 4'd7, 16'h6666, 16'h7777, 2'b10};
    tbl[14] = '{2'b01, 2'b00, 4'd6, 4'd0, 16'h0000, 16'h0000, 2'b01};
    tbl[15] = '{2'b10, 2'b00, 4'd0, 4'd7, 16'h0000, 16'h0000, 2'b10};

    // Reset state, then the full clear sweep.
    #12;
    check("reset rvalid", 64'(rvalid), 64'd0);
    check("reset init_done", 64'(init_done), 64'd0);
    check("b reset init_done", 64'(b_init_done), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(DEPTH);
    check("init_done after sweep", 64'(init_done), 64'd1);

    // Every location was zeroed over the non-zero preload.
    for (int i = 0; i < DEPTH; i++) begin
      apply(100 + i, '{2'b01, 2'b00, 4'(i), 4'd0, 16'h0, 16'h0, 2'b01});
    end

    for (int i = 0; i < 16; i++) apply(i, tbl[i]);
    apply(99, '{2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00});

    // Reset while a read is in flight drops its rvalid at once.
    @(negedge clk);
    req_valid = 2'b01; req_we = 2'b00; req_addr = {4'd0, 4'd3};
    @(posedge clk);
    #1;
    check("inflight rvalid", 64'(rvalid), 64'b01);
    rst_n = 1'b0;
    #1;
    check("async rvalid clear", 64'(rvalid), 64'd0);
    check("async init_done", 64'(init_done), 64'd0);
    req_valid = 2'b00;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reset again at cnt 7 mid-sweep: sweep must restart from address 0.
    sweep(7);
    #1;
    check("mid sweep addr", 64'(ram_addr), 64'd7);
    rst_n = 1'b0;
    #1;
    check("mid reset addr", 64'(ram_addr), 64'd0);
    check("mid reset init_done", 64'(init_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(DEPTH);
    check("init_done after resweep", 64'(init_done), 64'd1);
    apply(200, '{2'b01, 2'b00, 4'd3, 4'd0, 16'h0, 16'h0, 2'b01});
    apply(201, '{2'b00, 2'b00, 4'd0, 4'd0, 16'h0, 16'h0, 2'b00});
    @(negedge clk);

    // Instance without clear: serves a read on the first cycle after reset.
    check("b init_done in reset", 64'(b_init_done), 64'd1);
    rst_b_n = 1'b1;
    b_valid = 2'b01; b_we = 2'b00; b_addr = {4'd0, 4'd3};
    #1;
    check("b first ready", 64'(b_ready), 64'b01);
    check("b first bus", 64'({b_ram_en, b_ram_we, b_ram_addr}), 64'({1'b1, 1'b0, 4'd3}));
    @(posedge clk);
    #1;
    check("b rvalid", 64'(b_rvalid), 64'b01);
    check("b rdata", 64'(b_rdata), 64'h0103);
    @(negedge clk);
    b_valid = 2'b00;
    @(posedge clk);
    #1;
    check("b rvalid drop", 64'(b_rvalid), 64'd0);

    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
